seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
- Time-multiplexed scanner for the common-anode 7-segment display bank.
- Latches a packed multi-digit hex value once per frame. Steps through the digits and presents one 4-bit nibble per digit slot to the hex-to-7-segment decoder, driving the matching active-low anode enable.
- Inserts a dark gap between digits to prevent ghosting, and can optionally blank leading zeros.
- Sits between the CPU output/debug register and the segment decoder.

Parameters:
- NUM_DIGITS, 4, number of display digits (>=1); digit 0 is the least significant, rightmost digit.
- SHOW_CYCLES, 50000, clock cycles each digit is lit (>=1).
- GAP_CYCLES, 500, clock cycles of all-anodes-off between digits (0 = no gap state).
- CNT_W, 16, width of the dwell counter; must hold max(SHOW_CYCLES, GAP_CYCLES)-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  packed hex value; nibble i = value[4i+3:4i] = digit i.
- dp  in  NUM_DIGITS  decimal-point request per digit, active-high.
- blank_lz  in  1  1 = blank leading zero digits.
- hex  out  4  nibble to the segment decoder (registered).
- an  out  NUM_DIGITS  anode enables, active-low (registered).
- dp_n  out  1  decimal-point segment, active-low (registered).
- frame_tick  out  1  one-cycle pulse on the cycle the frame shadow is loaded (registered).

Behaviour:
- Reset values (registered on the clock edge while rst=1):
  - state=GAP, cnt=0, idx=NUM_DIGITS-1.
  - shadow value/dp/blank_lz = 0.
  - an = all 1, hex = 0, dp_n = 1, frame_tick = 0.
- Reset asserted mid-operation overrides everything on the next edge; no partial digit completes.
- FSM states:
  - GAP: an = all 1, hex = 0, dp_n = 1. Stays GAP_CYCLES cycles, cnt counting 0..GAP_CYCLES-1. On the last cycle: go to SHOW, idx = (idx==NUM_DIGITS-1) ? 0 : idx+1, cnt = 0.
  - SHOW: stays SHOW_CYCLES cycles. On the last cycle: go to GAP, cnt = 0. If GAP_CYCLES=0, go directly to SHOW of the next idx (GAP is never entered, including after reset, where the first cycle is directly SHOW digit 0).
- Frame latch:
  - Occurs on the transition into SHOW with new idx=0. The shadow registers load value, dp and blank_lz from the inputs on that edge, and frame_tick=1 for exactly that cycle.
  - Inputs changing at any other time have no effect until the next frame. This gives tear-free display.
- Output registers in SHOW are computed from the next idx and the next shadow, so the first SHOW cycle already shows the newly latched data:
  - hex = shadow nibble[idx].
  - an = all 1 except bit idx = 0.
  - dp_n = ~shadow_dp[idx].
- Leading-zero blanking:
  - Digit i (i>0) is blanked when shadow_blank_lz=1 and nibbles NUM_DIGITS-1 down to i are all 0.
  - Digit 0 is never blanked (value 0 shows "0").
  - A blanked digit keeps SHOW timing but outputs an = all 1, hex = 0, dp_n = 1.
- Latency: the value presented before the frame-latch edge appears on hex/an in the same cycle as frame_tick.
- Frame period = NUM_DIGITS*(SHOW_CYCLES+GAP_CYCLES) cycles.
- cnt never exceeds its terminal value. idx wraps NUM_DIGITS-1 -> 0. There are no other states; an illegal state recovers to GAP.

Test Plan (NUM_DIGITS=4, SHOW_CYCLES=4, GAP_CYCLES=2 unless noted):
- Reset, then scan:
  - Stimulus: rst=1 for 3 cycles, release, value=16'h1A2F, dp=0, blank_lz=0.
  - Required: an=4'b1111, hex=0 for 2 cycles.
  - Then an=4'b1110, hex=4'hF for 4 cycles with frame_tick=1 on the first of them.
  - Then 2 gap cycles, then an=4'b1101 hex=2, an=4'b1011 hex=A, an=4'b0111 hex=1.
  - Total frame 24 cycles.
- Tear-free latch:
  - Stimulus: change value to 16'h0000 while digit 2 is lit.
  - Required: digits 2,3 still show A,1; the next frame shows 0 on all digits.
- Leading-zero blank:
  - Stimulus: value=16'h0030, blank_lz=1.
  - Required: digit0 hex=0 an=1110, digit1 hex=3 an=1101, digits 2,3 an=1111.
  - Stimulus: value=0, blank_lz=1.
  - Required: only digit0 lit, hex=0.
- Decimal point:
  - Stimulus: dp=4'b0100.
  - Required: dp_n=0 only while an=4'b1011; dp_n=1 in all gaps and other digits.
- No gap:
  - Setup: GAP_CYCLES=0.
  - Required: an never all 1 after reset release; digits change every 4 cycles; frame period 16.
- Mid-operation reset:
  - Stimulus: assert rst during SHOW of digit 2.
  - Required: next cycle an=1111, hex=0, dp_n=1, frame_tick=0; after release, the scan restarts at digit 0 with a fresh latch.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed scanner for a common-anode 7-segment bank
// Purpose: latches a packed hex value once per frame and walks the digits,
//   presenting one nibble plus an active-low anode enable per digit slot. An
//   optional dark gap between digits suppresses ghosting, and leading zero
//   digits can be blanked.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   value      packed hex value, nibble i = digit i (digit 0 is rightmost)
//   dp         per-digit decimal point request, active-high
//   blank_lz   1 = blank leading zero digits
//   hex        nibble to the segment decoder (registered)
//   an         anode enables, active-low (registered)
//   dp_n       decimal point segment, active-low (registered)
//   frame_tick one-cycle pulse on the cycle the frame shadow loads (registered)
module seg7_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 50000,
  parameter int GAP_CYCLES  = 500,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // One-hot style encoding so the unused codes fall into the recovery branch.
  typedef enum logic [1:0] {
    ST_GAP  = 2'b01,
    ST_SHOW = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_blz_q, sh_blz_d;
  logic [3:0]              hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    enter_show;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   lz_blank;

  // Dwell sequencing and frame latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    sh_val_d     = sh_val_q;
    sh_dp_d      = sh_dp_q;
    sh_blz_d     = sh_blz_q;
    frame_tick_d = 1'b0;
    enter_show   = 1'b0;

    case (state_q)
      ST_GAP: begin
        // With no gap configured the reset GAP state is left on the first edge.
        if ((GAP_CYCLES == 0) || (cnt_q == GAP_LAST)) begin
          enter_show = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          if (GAP_CYCLES == 0) begin
            enter_show = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
        idx_d   = IDX_LAST;
      end
    endcase

    if (enter_show) begin
      state_d = ST_SHOW;
      cnt_d   = '0;
      if (idx_q == IDX_LAST) begin
        // Wrapping back to digit 0 starts a new frame: snapshot the inputs.
        idx_d        = '0;
        sh_val_d     = value;
        sh_dp_d      = dp;
        sh_blz_d     = blank_lz;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more significant digit are 0.
  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (sh_val_d[4*i +: 4] == 4'h0);
      if (i != 0) begin
        lz_blank[i] = sh_blz_d & upper_zero;
      end
    end
  end

  // Outputs follow the next state/shadow so newly latched data is visible
  // on the very first SHOW cycle of a frame.
  always_comb begin
    hex_d  = '0;
    an_d   = '1;
    dp_n_d = 1'b1;
    if ((state_d == ST_SHOW) && !lz_blank[idx_d]) begin
      hex_d       = sh_val_d[{idx_d, 2'b00} +: 4];
      an_d[idx_d] = 1'b0;
      dp_n_d      = ~sh_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_GAP;
      cnt_q        <= '0;
      idx_q        <= IDX_LAST;
      sh_val_q     <= '0;
      sh_dp_q      <= '0;
      sh_blz_q     <= 1'b0;
      hex_q        <= '0;
      an_q         <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_val_q     <= sh_val_d;
      sh_dp_q      <= sh_dp_d;
      sh_blz_q     <= sh_blz_d;
      hex_q        <= hex_d;
      an_q         <= an_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hex        = hex_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule
